// File: rtl/periph_uart_tx.sv
// Peripheral-bus responder with a transmit-only 8N1 UART, TX FIFO and programmable baud divider.
// Optional interrupt output enabled by defining PERIPH_UART_TX_IRQ_EN.
module periph_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        periph_mem_valid,
  input  logic [30:0] periph_mem_addr,
  input  logic        periph_mem_write,
  input  logic [31:0] periph_mem_wdata,
  input  logic [3:0]  periph_mem_wstrb,
  output logic [31:0] periph_mem_rdata,
  output logic        periph_mem_ready,
`ifdef PERIPH_UART_TX_IRQ_EN
  output logic        irq,
`endif
  output logic        uart_tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          ready_q;
  logic [31:0]   rdata_q, rdata_d, rd_val;
  logic [15:0]   bauddiv_q;
  logic          tx_en_q;
  logic          ovf_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [7:0]    fifo_rd;

  state_t        state_q, state_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          pop;

  logic          access, wr_acc, push_req, push;
  logic          fifo_full, fifo_empty, tx_idle, bit_end, start_ok;
  logic [1:0]    reg_sel;
  logic [7:0]    level_byte;
  logic          irq_en;

  // A request is serviced on the edge that raises ready; valid is ignored while ready is high.
  assign access     = periph_mem_valid && !ready_q;
  assign wr_acc     = access && periph_mem_write;
  assign reg_sel    = periph_mem_addr[3:2];
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push_req   = wr_acc && (reg_sel == 2'd0) && periph_mem_wstrb[0];
  assign push       = push_req && !fifo_full;
  assign tx_idle    = fifo_empty && (state_q == S_IDLE);
  assign level_byte = {{(8 - LW){1'b0}}, level_q};
  assign fifo_rd    = fifo_mem[rd_ptr_q];

  logic unused_ok;
  assign unused_ok = &{1'b0, periph_mem_addr[30:4], periph_mem_addr[1:0],
                       periph_mem_wdata[31:16], periph_mem_wstrb[3:2]};

`ifdef PERIPH_UART_TX_IRQ_EN
  logic irq_en_q, irq_q;
  assign irq_en = irq_en_q;
  assign irq    = irq_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_acc && (reg_sel == 2'd3) && periph_mem_wstrb[0]) irq_en_q <= periph_mem_wdata[1];
      irq_q <= irq_en_q && tx_idle;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd1:    rd_val = {16'b0, level_byte, 5'b0, ovf_q, tx_idle, fifo_full};
      2'd2:    rd_val = {16'b0, bauddiv_q};
      2'd3:    rd_val = {30'b0, irq_en, tx_en_q};
      default: rd_val = '0;
    endcase
    rdata_d = (access && !periph_mem_write) ? rd_val : '0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      bauddiv_q <= DEFAULT_DIV;
      tx_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ready_q <= access;
      rdata_q <= rdata_d;
      if (wr_acc && (reg_sel == 2'd2)) begin
        if (periph_mem_wstrb[0]) bauddiv_q[7:0]  <= periph_mem_wdata[7:0];
        if (periph_mem_wstrb[1]) bauddiv_q[15:8] <= periph_mem_wdata[15:8];
      end
      if (wr_acc && (reg_sel == 2'd3) && periph_mem_wstrb[0]) tx_en_q <= periph_mem_wdata[0];
      // A drop on the same cycle as the W1C clear keeps overflow set.
      if (push_req && fifo_full)
        ovf_q <= 1'b1;
      else if (wr_acc && (reg_sel == 2'd1) && periph_mem_wstrb[0] && periph_mem_wdata[2])
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= periph_mem_wdata[7:0];
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign bit_end  = (baud_cnt_q == 16'd0);
  assign start_ok = tx_en_q && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q - 16'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = baud_cnt_q;
        tx_d       = 1'b1;
        if (start_ok) begin
          pop        = 1'b1;
          state_d    = S_START;
          baud_cnt_d = bauddiv_q;
          shift_d    = fifo_rd;
          tx_d       = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d    = S_DATA;
          baud_cnt_d = bauddiv_q;
          bit_cnt_d  = 3'd0;
          tx_d       = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_d = bauddiv_q;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next START so queued frames run back to back.
          if (start_ok) begin
            pop        = 1'b1;
            state_d    = S_START;
            baud_cnt_d = bauddiv_q;
            shift_d    = fifo_rd;
            tx_d       = 1'b0;
          end else begin
            state_d    = S_IDLE;
            baud_cnt_d = baud_cnt_q;
            tx_d       = 1'b1;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = baud_cnt_q;
        tx_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign periph_mem_ready = ready_q;
  assign periph_mem_rdata = rdata_q;
  assign uart_tx          = tx_q;

endmodule
